// File: rtl/composite_timing_gen.sv
// Composite-video timing generator: H/V counters, serrated vsync, pixel fetch,
// and a two-stage output pipeline driving a resistor-ladder DAC code.
module composite_timing_gen #(
  parameter int DAC_BITS     = 2,
  parameter int LINE_CYCLES  = 1716,
  parameter int HSYNC_CYCLES = 127,
  parameter int ACTIVE_START = 310,
  parameter int PIXELS       = 256,
  parameter int PIXEL_CYCLES = 5,
  parameter int LINES        = 262,
  parameter int ACTIVE_LINES = 240,
  parameter int VSYNC_LINE   = 248,
  parameter int VSYNC_LINES  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DAC_BITS-1:0]         pixel_data,
  output logic                        pixel_req,
  output logic [$clog2(PIXELS)-1:0]   pixel_x,
  output logic [$clog2(LINES)-1:0]    pixel_y,
  output logic [DAC_BITS-1:0]         dac,
  output logic                        line_start,
  output logic                        frame_start
);

  localparam int HW = $clog2(LINE_CYCLES + 1);
  localparam int VW = $clog2(LINES + 1);
  localparam int XW = $clog2(PIXELS);
  localparam int YW = $clog2(LINES);
  localparam int PW = $clog2(PIXEL_CYCLES + 1);
  localparam int VID_END = ACTIVE_START + PIXELS * PIXEL_CYCLES;

  localparam logic [HW-1:0] H_LAST  = HW'(LINE_CYCLES - 1);
  localparam logic [HW-1:0] H_SYNC  = HW'(HSYNC_CYCLES);
  localparam logic [HW-1:0] H_AS    = HW'(ACTIVE_START);
  localparam logic [HW-1:0] H_FETCH = HW'(ACTIVE_START - 2);
  localparam logic [HW-1:0] H_VEND  = HW'(VID_END);
  localparam logic [HW-1:0] H_SERR  = HW'(LINE_CYCLES - HSYNC_CYCLES);
  localparam logic [VW-1:0] V_LAST  = VW'(LINES - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(ACTIVE_LINES);
  localparam logic [VW-1:0] V_VS0   = VW'(VSYNC_LINE);
  localparam logic [VW-1:0] V_VS1   = VW'(VSYNC_LINE + VSYNC_LINES);
  localparam logic [XW-1:0] X_LAST  = XW'(PIXELS - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(PIXEL_CYCLES - 1);
  localparam logic [DAC_BITS-1:0] TIP   = '0;
  localparam logic [DAC_BITS-1:0] BLACK = DAC_BITS'(1);

  if (ACTIVE_START < HSYNC_CYCLES + 2) begin : g_chk_as
    $error("ACTIVE_START too close to hsync");
  end
  if (VID_END > LINE_CYCLES) begin : g_chk_vid
    $error("active video overruns the line");
  end
  if (VSYNC_LINE + VSYNC_LINES > LINES) begin : g_chk_vs
    $error("vsync lines overrun the frame");
  end
  if (ACTIVE_LINES > VSYNC_LINE) begin : g_chk_al
    $error("active lines overlap vsync");
  end
  if (PIXEL_CYCLES < 1) begin : g_chk_pc
    $error("PIXEL_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {LN_ACTIVE, LN_BLANK, LN_VSYNC} line_t;
  typedef enum logic [1:0] {
    PH_SYNC, PH_BACK, PH_VIDEO, PH_FRONT
  } phase_t;

  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [DAC_BITS-1:0] lvl_q, lvl_d, dac_q;
  logic [DAC_BITS-1:0] code_q, code;
  logic                ls1_q, fs1_q, ls_q, fs_q;
  logic                req_q, req_d, cap_q, on_q, on_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [PW-1:0]       ph_q, ph_d;
  line_t               line;
  phase_t              phase;
  logic                wrap;

  assign wrap = (h_q == H_LAST);
  assign h_d  = wrap ? '0 : h_q + 1'b1;
  assign v_d  = !wrap ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;

  // A zero pixel code would read as a sync tip, so it is lifted to black.
  assign code = (code_q == TIP) ? BLACK : code_q;

  always_comb begin
    line = LN_BLANK;
    if (v_q < V_ACT)
      line = LN_ACTIVE;
    else if (v_q >= V_VS0 && v_q < V_VS1)
      line = LN_VSYNC;
    phase = PH_FRONT;
    if (h_q < H_SYNC)      phase = PH_SYNC;
    else if (h_q < H_AS)   phase = PH_BACK;
    else if (h_q < H_VEND) phase = PH_VIDEO;
    lvl_d = BLACK;
    unique case (line)
      LN_ACTIVE: begin
        if (phase == PH_SYNC)       lvl_d = TIP;
        else if (phase == PH_VIDEO) lvl_d = code;
      end
      LN_VSYNC: lvl_d = (h_q < H_SERR) ? TIP : BLACK;
      default:  lvl_d = (phase == PH_SYNC) ? TIP : BLACK;
    endcase
  end

  // Fetch schedule runs on the next-state count so the strobe is registered.
  always_comb begin
    req_d = 1'b0;
    x_d   = x_q;
    y_d   = y_q;
    ph_d  = ph_q;
    on_d  = on_q;
    if (h_d == H_FETCH && v_d < V_ACT) begin
      req_d = 1'b1;
      x_d   = '0;
      y_d   = YW'(v_d);
      ph_d  = '0;
      on_d  = 1'b1;
    end else if (on_q) begin
      if (ph_q == P_LAST) begin
        ph_d = '0;
        if (x_q == X_LAST) begin
          on_d = 1'b0;
        end else begin
          req_d = 1'b1;
          x_d   = x_q + 1'b1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      lvl_q  <= BLACK;
      dac_q  <= BLACK;
      ls1_q  <= 1'b0;
      fs1_q  <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      req_q  <= 1'b0;
      cap_q  <= 1'b0;
      code_q <= '0;
      on_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ph_q   <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      lvl_q  <= lvl_d;
      dac_q  <= lvl_q;
      ls1_q  <= (h_q == '0);
      fs1_q  <= (h_q == '0) && (v_q == '0);
      ls_q   <= ls1_q;
      fs_q   <= fs1_q;
      req_q  <= req_d;
      cap_q  <= req_q;
      if (cap_q) code_q <= pixel_data;
      on_q   <= on_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ph_q   <= ph_d;
    end
  end

  assign pixel_req   = req_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign dac         = dac_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
